// File: rtl/rand_pkg.sv
// Shared types and constants for the random-number history display.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package rand_pkg;

  typedef enum logic {
    S_LIVE,
    S_RECALL
  } state_t;

  localparam int HIST_DEPTH = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/seg7_dec.sv
// Decimal digit to active-low 7-segment pattern, with a blank override.
// Codes 10..15 never reach here in normal use and show blank.
module seg7_dec
  import rand_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      unique case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/rand_history.sv
// Four-entry history of random numbers with a recall/browse mode.
// Display registers are loaded from next-state values for 1-cycle latency.
module rand_history
  import rand_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [3:0] i_data,
  input  logic       i_recall,
  output logic [6:0] o_hex_tens,
  output logic [6:0] o_hex_units,
  output logic [1:0] o_offset,
  output logic [2:0] o_count
);

  localparam logic [2:0] CNT_MAX  = 3'(HIST_DEPTH);
  localparam logic [7:0] IDLE_END = 8'(IDLE_TIMEOUT - 1);

  logic [3:0] hist [HIST_DEPTH];
  logic [1:0] wptr_q, wptr_n;
  logic [2:0] cnt_q, cnt_n;
  logic [1:0] off_q, off_n;
  logic [7:0] idle_q, idle_n;
  state_t     state_q, state_n;

  logic [1:0] rd_idx;
  logic [3:0] val;
  logic [3:0] units_digit;
  logic       tens_blank;
  logic       units_blank;
  logic [6:0] tens_seg;
  logic [6:0] units_seg;

  always_comb begin
    wptr_n  = wptr_q;
    cnt_n   = cnt_q;
    off_n   = off_q;
    idle_n  = idle_q;
    state_n = state_q;
    if (i_valid) begin
      wptr_n  = wptr_q + 2'd1;
      cnt_n   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 3'd1;
      off_n   = 2'd0;
      idle_n  = 8'd0;
      state_n = S_LIVE;
    end else if (state_q == S_LIVE) begin
      if (i_recall && cnt_q >= 3'd2) begin
        state_n = S_RECALL;
        off_n   = 2'd1;
        idle_n  = 8'd0;
      end
    end else if (i_recall) begin
      idle_n = 8'd0;
      if ({1'b0, off_q} + 3'd1 == cnt_q) begin
        state_n = S_LIVE;
        off_n   = 2'd0;
      end else begin
        off_n = off_q + 2'd1;
      end
    end else if (idle_q == IDLE_END) begin
      state_n = S_LIVE;
      off_n   = 2'd0;
      idle_n  = 8'd0;
    end else begin
      idle_n = idle_q + 8'd1;
    end
  end

  // A fresh sample is always shown at offset 0, so bypass the array.
  always_comb begin
    rd_idx      = wptr_q - 2'd1 - off_n;
    val         = i_valid ? i_data : hist[rd_idx];
    tens_blank  = (cnt_n == 3'd0) || (val < 4'd10);
    units_blank = (cnt_n == 3'd0);
    units_digit = (val >= 4'd10) ? val - 4'd10 : val;
  end

  seg7_dec u_tens (
    .digit (4'd1),
    .blank (tens_blank),
    .seg   (tens_seg)
  );

  seg7_dec u_units (
    .digit (units_digit),
    .blank (units_blank),
    .seg   (units_seg)
  );

  always_ff @(posedge i_clk) begin
    if (i_valid) hist[wptr_q] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_LIVE;
      wptr_q      <= 2'd0;
      cnt_q       <= 3'd0;
      off_q       <= 2'd0;
      idle_q      <= 8'd0;
      o_hex_tens  <= SEG_BLANK;
      o_hex_units <= SEG_BLANK;
    end else begin
      state_q     <= state_n;
      wptr_q      <= wptr_n;
      cnt_q       <= cnt_n;
      off_q       <= off_n;
      idle_q      <= idle_n;
      o_hex_tens  <= tens_seg;
      o_hex_units <= units_seg;
    end
  end

  assign o_offset = off_q;
  assign o_count  = cnt_q;

endmodule

// File: tb/tb_rand_history.sv
// Directed bench for rand_history: storage, recall walk, timeout,
// valid/recall priority and asynchronous reset.
module tb_rand_history;

  localparam int TO = 16;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D6 = 7'b0000010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] D9 = 7'b0010000;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [3:0] i_data = 4'd0;
  logic       i_recall = 1'b0;
  logic [6:0] o_hex_tens;
  logic [6:0] o_hex_units;
  logic [1:0] o_offset;
  logic [2:0] o_count;

  int n_cmp = 0;
  int n_bad = 0;

  rand_history #(.IDLE_TIMEOUT(TO)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .i_recall    (i_recall),
    .o_hex_tens  (o_hex_tens),
    .o_hex_units (o_hex_units),
    .o_offset    (o_offset),
    .o_count     (o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic disp(input string tag, input logic [6:0] t,
                      input logic [6:0] u, input int off, input int cnt);
    check({tag, ".tens"}, int'(o_hex_tens), int'(t));
    check({tag, ".units"}, int'(o_hex_units), int'(u));
    check({tag, ".off"}, int'(o_offset), off);
    check({tag, ".cnt"}, int'(o_count), cnt);
  endtask

  // Drive for one edge, then sample 1 time unit after it.
  task automatic step(input logic v, input logic [3:0] d, input logic r);
    i_valid  = v;
    i_data   = d;
    i_recall = r;
    @(posedge i_clk);
    #1;
    i_valid  = 1'b0;
    i_recall = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    do_reset();
    disp("reset", BL, BL, 0, 0);

    step(1, 4'd12, 0);
    disp("v12", D1, D2, 0, 1);
    step(0, 4'd0, 1);
    disp("rc_cnt1", D1, D2, 0, 1);

    do_reset();
    step(1, 4'd3, 0);
    step(1, 4'd7, 0);
    step(1, 4'd15, 0);
    disp("s15", D1, D5, 0, 3);
    step(0, 4'd0, 1);
    disp("rc7", BL, D7, 1, 3);
    step(0, 4'd0, 1);
    disp("rc3", BL, D3, 2, 3);
    step(0, 4'd0, 1);
    disp("wrap15", D1, D5, 0, 3);

    do_reset();
    for (int k = 1; k <= 5; k++) step(1, 4'(k), 0);
    disp("s5", BL, D5, 0, 4);
    step(0, 4'd0, 1);
    disp("rc4", BL, D4, 1, 4);
    step(0, 4'd0, 1);
    disp("rc3b", BL, D3, 2, 4);
    step(0, 4'd0, 1);
    disp("rc2", BL, D2, 3, 4);
    step(0, 4'd0, 1);
    disp("wrap5", BL, D5, 0, 4);

    step(0, 4'd0, 1);
    disp("to_enter", BL, D4, 1, 4);
    for (int k = 0; k < TO - 1; k++) step(0, 4'd0, 0);
    disp("to_m1", BL, D4, 1, 4);
    step(0, 4'd0, 0);
    disp("to_hit", BL, D5, 0, 4);

    step(0, 4'd0, 1);
    step(0, 4'd0, 1);
    disp("pri_pre", BL, D3, 2, 4);
    step(1, 4'd9, 1);
    disp("pri", BL, D9, 0, 4);

    step(0, 4'd0, 1);
    disp("rst_pre", BL, D5, 1, 4);
    #2 i_rst = 1'b1;
    #1;
    disp("rst_async", BL, BL, 0, 0);
    #1 i_rst = 1'b0;
    step(0, 4'd0, 1);
    disp("rst_rc", BL, BL, 0, 0);
    step(1, 4'd6, 0);
    disp("rst_v6", BL, D6, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
